// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction RAM (port B).
// Takes a program as a byte stream with a valid/ready handshake. The frame is big-endian:
// LEN_HI, LEN_LO, then N x (W_HI, W_LO), then CS_HI, CS_LO. Each 16-bit word is written once,
// in order, starting at BASE_ADDR. The CPU is held while a load runs. It is released only when
// the received checksum matches the sum of the written words.
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   start                 begin a load (honoured in IDLE/DONE/ERR only)
//   byte_in, byte_valid   stream input
//   byte_ready            loader accepts a byte this cycle
//   mem_addr, mem_data    RAM port B address / write data
//   mem_wren              RAM port B write enable (single-cycle pulses)
//   cpu_hold              stall the CPU pipeline
//   done, error           sticky load status until next start
//   words_loaded          words written in the current/last load
//   checksum              running mod-2^16 sum of written words
module imem_loader #(
    parameter int unsigned MAX_WORDS = 1024,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data,
    output logic        mem_wren,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded,
    output logic [15:0] checksum
);

    typedef enum logic [3:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StDataHi,
        StDataLo,
        StWrite,
        StCsumHi,
        StCsumLo,
        StDone,
        StErr
    } state_t;

    state_t      state;
    logic [15:0] len;
    logic [7:0]  hi_byte;

    logic        xfer;
    logic [15:0] rx_word;
    logic [15:0] next_count;
    logic        len_too_big;

    assign xfer        = byte_valid && byte_ready;
    assign rx_word     = {hi_byte, byte_in};
    assign next_count  = words_loaded + 16'd1;
    assign len_too_big = 32'(rx_word) > MAX_WORDS;

    // Both are plain decodes of the state register.
    // The write pulse and the ready window therefore never overlap.
    assign byte_ready = state inside {StLenHi, StLenLo, StDataHi, StDataLo, StCsumHi, StCsumLo};
    assign mem_wren   = (state == StWrite);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= StIdle;
            len          <= 16'd0;
            hi_byte      <= 8'd0;
            mem_addr     <= 16'd0;
            mem_data     <= 16'd0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 16'd0;
            checksum     <= 16'd0;
        end else begin
            case (state)
                StIdle, StDone, StErr: begin
                    if (start) begin
                        state        <= StLenHi;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= 16'd0;
                        checksum     <= 16'd0;
                    end
                end
                StLenHi: begin
                    if (xfer) begin
                        hi_byte <= byte_in;
                        state   <= StLenLo;
                    end
                end
                StLenLo: begin
                    if (xfer) begin
                        len <= rx_word;
                        if (len_too_big) begin
                            state <= StErr;
                            done  <= 1'b1;
                            error <= 1'b1;
                        end else if (rx_word == 16'd0) begin
                            state <= StCsumHi;
                        end else begin
                            state <= StDataHi;
                        end
                    end
                end
                StDataHi: begin
                    if (xfer) begin
                        hi_byte <= byte_in;
                        state   <= StDataLo;
                    end
                end
                StDataLo: begin
                    if (xfer) begin
                        mem_data <= rx_word;
                        mem_addr <= BASE_ADDR + words_loaded;  // wraps mod 2^16
                        state    <= StWrite;
                    end
                end
                StWrite: begin
                    words_loaded <= next_count;
                    checksum     <= checksum + mem_data;
                    state        <= (next_count < len) ? StDataHi : StCsumHi;
                end
                StCsumHi: begin
                    if (xfer) begin
                        hi_byte <= byte_in;
                        state   <= StCsumLo;
                    end
                end
                StCsumLo: begin
                    if (xfer) begin
                        done <= 1'b1;
                        if (rx_word == checksum) begin
                            state    <= StDone;
                            error    <= 1'b0;
                            cpu_hold <= 1'b0;
                        end else begin
                            // Keep the CPU held: a partial or corrupt image must not run.
                            state <= StErr;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus random frames.
// A frame-level reference model supplies every expected value.
module tb_imem_loader;

    localparam int unsigned MaxWords = 1024;
    localparam logic [15:0] BaseAddr = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_wren;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;
    logic [15:0] checksum;

    imem_loader #(
        .MAX_WORDS (MaxWords),
        .BASE_ADDR (BaseAddr)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_wren     (mem_wren),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded),
        .checksum     (checksum)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed RAM writes
    logic [15:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          cyc = 0;
    int          last_wr = -100;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_wren === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_data);
            check("ready_low_in_write", 32'(byte_ready), 32'd0);
            check("write_gap_ge3", 32'((cyc - last_wr) >= 3), 32'd1);
            last_wr = cyc;
        end
    end

    // Current frame content
    logic [15:0] word_q[$];
    logic [7:0]  frame_q[$];

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_data"}, 32'(mem_data), 32'd0);
        check({tag, "_wren"}, 32'(mem_wren), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'd0);
        check({tag, "_csum"}, 32'(checksum), 32'd0);
    endtask

    // Build a frame of length n from word_q with checksum cs, drive it, and compare with the model.
    task automatic run_frame(input string tag, input logic [15:0] n, input logic [15:0] cs,
                             input int valid_pct);
        logic        len_err;
        logic [15:0] exp_sum;
        logic        exp_err;
        logic [15:0] exp_words;
        int          idx;
        int          budget;
        logic        xfer;
        logic        is_lo;

        len_err = 32'(n) > MaxWords;
        exp_sum = 16'd0;
        frame_q.delete();
        frame_q.push_back(n[15:8]);
        frame_q.push_back(n[7:0]);
        if (len_err) begin
            exp_err   = 1'b1;
            exp_words = 16'd0;
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                frame_q.push_back(word_q[i][15:8]);
                frame_q.push_back(word_q[i][7:0]);
                exp_sum = exp_sum + word_q[i];
            end
            frame_q.push_back(cs[15:8]);
            frame_q.push_back(cs[7:0]);
            exp_err   = (cs != exp_sum);
            exp_words = n;
        end

        wr_addr_q.delete();
        wr_data_q.delete();

        // Start pulse with a junk byte offered in the same cycle; it must not be taken.
        @(negedge clk);
        start      = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'hA5;
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
        check({tag, "_start_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_start_done"}, 32'(done), 32'd0);
        check({tag, "_start_err"}, 32'(error), 32'd0);
        check({tag, "_start_words"}, 32'(words_loaded), 32'd0);
        check({tag, "_start_csum"}, 32'(checksum), 32'd0);

        idx    = 0;
        budget = 0;
        while (idx < frame_q.size() && budget < 20000) begin
            byte_valid = ($urandom_range(99) < valid_pct);
            byte_in    = byte_valid ? frame_q[idx] : 8'($urandom);
            xfer       = byte_valid && byte_ready;
            is_lo      = !len_err && idx >= 3 && idx < 2 + 2 * int'(n) && (idx % 2 == 1);
            @(posedge clk);
            budget++;
            if (xfer) idx++;
            @(negedge clk);
            if (xfer && is_lo) check({tag, "_wr_latency"}, 32'(mem_wren), 32'd1);
        end
        byte_valid = 1'b0;
        if (budget >= 20000) check({tag, "_timeout"}, 32'd0, 32'd1);

        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_error"}, 32'(error), 32'(exp_err));
        check({tag, "_hold"}, 32'(cpu_hold), 32'(exp_err));
        check({tag, "_words"}, 32'(words_loaded), 32'(exp_words));
        check({tag, "_csum"}, 32'(checksum), 32'(exp_sum));
        repeat (3) @(negedge clk);
        check({tag, "_ready_after"}, 32'(byte_ready), 32'd0);
        check({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(exp_words));
        if (wr_addr_q.size() == int'(exp_words)) begin
            for (int i = 0; i < int'(exp_words); i++) begin
                check({tag, "_wr_addr"}, 32'(wr_addr_q[i]), 32'(BaseAddr + 16'(i)));
                check({tag, "_wr_data"}, 32'(wr_data_q[i]), 32'(word_q[i]));
            end
        end
    endtask

    task automatic set_test1_words();
        word_q.delete();
        word_q.push_back(16'h1234);
        word_q.push_back(16'hABCD);
    endtask

    initial begin
        logic [15:0] n;
        logic [15:0] s;
        logic [15:0] cs;
        int          budget;
        int          k;

        reset      = 1'b1;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle");

        // 1) good two-word frame, back-to-back bytes
        set_test1_words();
        run_frame("t1", 16'd2, 16'hBE01, 100);
        // 2) bad checksum
        run_frame("t2", 16'd2, 16'hBE00, 100);
        // 3) oversize length
        word_q.delete();
        run_frame("t3", 16'd1025, 16'h0000, 100);
        // 4) empty program
        run_frame("t4a", 16'd0, 16'h0000, 100);
        run_frame("t4b", 16'd0, 16'h0001, 100);
        // 5) throttled stream
        set_test1_words();
        run_frame("t5", 16'd2, 16'hBE01, 40);

        // 6) reset after the first word is written
        wr_addr_q.delete();
        wr_data_q.delete();
        frame_q.delete();
        frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h01};
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        k      = 0;
        budget = 0;
        while (wr_addr_q.size() == 0 && budget < 100) begin
            byte_valid = 1'b1;
            byte_in    = frame_q[k];
            if (byte_ready) k++;
            @(negedge clk);
            budget++;
        end
        check("t6_first_write", 32'(wr_addr_q.size()), 32'd1);
        #2 reset = 1'b1;
        #1 check_reset_outputs("t6_reset");
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_no_more_writes", 32'(wr_addr_q.size()), 32'd1);
        reset = 1'b0;
        set_test1_words();
        run_frame("t6_reload", 16'd2, 16'hBE01, 100);

        // Random frames
        for (int f = 0; f < 10; f++) begin
            n = 16'($urandom_range(0, 12));
            word_q.delete();
            s = 16'd0;
            for (int i = 0; i < int'(n); i++) begin
                word_q.push_back(16'($urandom));
                s = s + word_q[i];
            end
            cs = ($urandom_range(3) == 0) ? s ^ 16'($urandom_range(1, 65535)) : s;
            run_frame("rand", n, cs, int'($urandom_range(30, 100)));
        end

        // Largest accepted length
        word_q.delete();
        s = 16'd0;
        for (int i = 0; i < int'(MaxWords); i++) begin
            word_q.push_back(16'($urandom));
            s = s + word_q[i];
        end
        run_frame("max", 16'(MaxWords), s, 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
